// File: rtl/debug_cmd_rx_pkg.sv
// Shared constants, state encodings and ASCII helpers
// for the debug console command receiver.
package debug_cmd_rx_pkg;

  localparam int CLK_FREQ_DEF  = 27000000;
  localparam int UART_FREQ_DEF = 115200;

  function automatic int calc_bit_div(
    input int clk_hz,
    input int baud
  );
    return (clk_hz + baud / 2) / baud;
  endfunction

  localparam int BIT_DIV  =
    calc_bit_div(CLK_FREQ_DEF, UART_FREQ_DEF);
  localparam int HALF_DIV = BIT_DIV / 2;

  localparam logic [7:0] ASC_R  = 8'h52;
  localparam logic [7:0] ASC_C  = 8'h43;
  localparam logic [7:0] ASC_S  = 8'h53;
  localparam logic [7:0] ASC_LF = 8'h0A;
  localparam logic [7:0] ASC_CR = 8'h0D;

  typedef enum logic [2:0] {
    RX_IDLE,
    RX_START,
    RX_DATA,
    RX_STOP,
    RX_WAIT_HIGH
  } rx_state_t;

  typedef enum logic [2:0] {
    P_IDLE,
    P_EOL_R,
    P_EOL_C,
    P_HI,
    P_LO,
    P_EOL_S,
    P_DISCARD
  } p_state_t;

  function automatic logic is_eol(input logic [7:0] b);
    return (b == ASC_LF) || (b == ASC_CR);
  endfunction

  function automatic logic [7:0] to_upper(
    input logic [7:0] b
  );
    if (b >= 8'h61 && b <= 8'h7A)
      return b - 8'h20;
    return b;
  endfunction

  // Expects an already upper-cased byte.
  function automatic logic is_hex(input logic [7:0] b);
    return (b >= 8'h30 && b <= 8'h39) ||
           (b >= 8'h41 && b <= 8'h46);
  endfunction

  function automatic logic [3:0] hex_nib(
    input logic [7:0] b
  );
    if (b <= 8'h39)
      return b[3:0];
    return 4'(b[3:0] + 4'd9);
  endfunction

endpackage

// File: rtl/debug_cmd_rx_uart_rx_core.sv
// 8N1 UART receiver: line synchroniser, bit-timing FSM,
// byte output and saturating framing-error counter.
module uart_rx_core
  import debug_cmd_rx_pkg::*;
#(
  parameter int CLK_FREQ  = CLK_FREQ_DEF,
  parameter int UART_FREQ = UART_FREQ_DEF
) (
  input  logic       i_clk,
  input  logic       i_rst_n,
  input  logic       i_rx,
  output logic [7:0] o_data,
  output logic       o_valid,
  output logic [7:0] o_ferr_cnt
);

  localparam int BDIV = calc_bit_div(CLK_FREQ, UART_FREQ);
  localparam int HDIV = BDIV / 2;
  localparam logic [15:0] BIT_LAST  = 16'(BDIV - 1);
  localparam logic [15:0] HALF_LAST = 16'(HDIV - 1);

  rx_state_t   r_state;
  logic [1:0]  r_sync;
  logic [15:0] r_cnt;
  logic [2:0]  r_bit;
  logic [7:0]  r_shift;
  logic [7:0]  r_data;
  logic        r_valid;
  logic [7:0]  r_ferr;

  rx_state_t   w_state_nxt;
  logic [15:0] w_cnt_nxt;
  logic [2:0]  w_bit_nxt;
  logic [7:0]  w_shift_nxt;
  logic [7:0]  w_data_nxt;
  logic        w_valid_nxt;
  logic [7:0]  w_ferr_nxt;
  logic        w_line;

  assign w_line = r_sync[1];

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_sync  <= 2'b11;
      r_state <= RX_IDLE;
      r_cnt   <= '0;
      r_bit   <= '0;
      r_shift <= '0;
      r_data  <= '0;
      r_valid <= 1'b0;
      r_ferr  <= '0;
    end else begin
      r_sync  <= {r_sync[0], i_rx};
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
      r_bit   <= w_bit_nxt;
      r_shift <= w_shift_nxt;
      r_data  <= w_data_nxt;
      r_valid <= w_valid_nxt;
      r_ferr  <= w_ferr_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_bit_nxt   = r_bit;
    w_shift_nxt = r_shift;
    w_data_nxt  = r_data;
    w_valid_nxt = 1'b0;
    w_ferr_nxt  = r_ferr;
    unique case (r_state)
      RX_IDLE: begin
        if (!w_line) begin
          w_cnt_nxt   = '0;
          w_bit_nxt   = '0;
          w_state_nxt = RX_START;
        end
      end
      RX_START: begin
        if (r_cnt == HALF_LAST) begin
          w_cnt_nxt   = '0;
          w_state_nxt = w_line ? RX_IDLE : RX_DATA;
        end else begin
          w_cnt_nxt = r_cnt + 16'd1;
        end
      end
      RX_DATA: begin
        if (r_cnt == BIT_LAST) begin
          w_cnt_nxt   = '0;
          w_shift_nxt = {w_line, r_shift[7:1]};
          w_bit_nxt   = r_bit + 3'd1;
          if (r_bit == 3'd7)
            w_state_nxt = RX_STOP;
        end else begin
          w_cnt_nxt = r_cnt + 16'd1;
        end
      end
      RX_STOP: begin
        if (r_cnt == BIT_LAST) begin
          w_cnt_nxt = '0;
          if (w_line) begin
            w_data_nxt  = r_shift;
            w_valid_nxt = 1'b1;
            w_state_nxt = RX_IDLE;
          end else begin
            if (r_ferr != 8'hFF)
              w_ferr_nxt = r_ferr + 8'd1;
            w_state_nxt = RX_WAIT_HIGH;
          end
        end else begin
          w_cnt_nxt = r_cnt + 16'd1;
        end
      end
      // A break holds the line low; wait it out.
      RX_WAIT_HIGH: begin
        if (w_line)
          w_state_nxt = RX_IDLE;
      end
      default: w_state_nxt = RX_IDLE;
    endcase
  end

  assign o_data     = r_data;
  assign o_valid    = r_valid;
  assign o_ferr_cnt = r_ferr;

endmodule

// File: rtl/debug_cmd_rx.sv
// Debug console receiver: UART bytes in, parsed
// R / C / Shh line commands out as one-cycle pulses.
module debug_cmd_rx
  import debug_cmd_rx_pkg::*;
#(
  parameter int CLK_FREQ  = CLK_FREQ_DEF,
  parameter int UART_FREQ = UART_FREQ_DEF
) (
  input  logic       clk_27m,
  input  logic       reset_n,
  input  logic       uart_rx,
  output logic [7:0] rx_data,
  output logic       rx_valid,
  output logic       send_req,
  output logic       clear_req,
  output logic [7:0] sel,
  output logic       sel_valid,
  output logic       cmd_err,
  output logic [7:0] frame_err_cnt
);

  logic [7:0] w_rx_data;
  logic       w_rx_valid;
  logic [7:0] w_ferr;

  uart_rx_core #(
    .CLK_FREQ  (CLK_FREQ),
    .UART_FREQ (UART_FREQ)
  ) u_core (
    .i_clk      (clk_27m),
    .i_rst_n    (reset_n),
    .i_rx       (uart_rx),
    .o_data     (w_rx_data),
    .o_valid    (w_rx_valid),
    .o_ferr_cnt (w_ferr)
  );

  p_state_t   r_p;
  logic [7:0] r_nib;
  logic [7:0] r_sel;
  logic       r_send;
  logic       r_clear;
  logic       r_selv;
  logic       r_err;

  p_state_t   w_p_nxt;
  logic [7:0] w_nib_nxt;
  logic [7:0] w_sel_nxt;
  logic       w_send_nxt;
  logic       w_clear_nxt;
  logic       w_selv_nxt;
  logic       w_err_nxt;
  logic [7:0] w_u;
  logic       w_eol;
  logic       w_hex;
  logic [3:0] w_nib;

  assign w_u   = to_upper(w_rx_data);
  assign w_eol = is_eol(w_rx_data);
  assign w_hex = is_hex(w_u);
  assign w_nib = hex_nib(w_u);

  always_ff @(posedge clk_27m or negedge reset_n) begin
    if (!reset_n) begin
      r_p     <= P_IDLE;
      r_nib   <= '0;
      r_sel   <= '0;
      r_send  <= 1'b0;
      r_clear <= 1'b0;
      r_selv  <= 1'b0;
      r_err   <= 1'b0;
    end else begin
      r_p     <= w_p_nxt;
      r_nib   <= w_nib_nxt;
      r_sel   <= w_sel_nxt;
      r_send  <= w_send_nxt;
      r_clear <= w_clear_nxt;
      r_selv  <= w_selv_nxt;
      r_err   <= w_err_nxt;
    end
  end

  always_comb begin
    w_p_nxt     = r_p;
    w_nib_nxt   = r_nib;
    w_sel_nxt   = r_sel;
    w_send_nxt  = 1'b0;
    w_clear_nxt = 1'b0;
    w_selv_nxt  = 1'b0;
    w_err_nxt   = 1'b0;
    if (w_rx_valid) begin
      unique case (r_p)
        P_IDLE: begin
          unique case (1'b1)
            (w_u == ASC_R): w_p_nxt = P_EOL_R;
            (w_u == ASC_C): w_p_nxt = P_EOL_C;
            (w_u == ASC_S): w_p_nxt = P_HI;
            w_eol:          w_p_nxt = P_IDLE;
            default: begin
              w_err_nxt = 1'b1;
              w_p_nxt   = P_DISCARD;
            end
          endcase
        end
        P_HI, P_LO: begin
          if (w_eol) begin
            w_err_nxt = 1'b1;
            w_p_nxt   = P_IDLE;
          end else if (!w_hex) begin
            w_err_nxt = 1'b1;
            w_p_nxt   = P_DISCARD;
          end else if (r_p == P_HI) begin
            w_nib_nxt[7:4] = w_nib;
            w_p_nxt        = P_LO;
          end else begin
            w_nib_nxt[3:0] = w_nib;
            w_p_nxt        = P_EOL_S;
          end
        end
        P_EOL_R, P_EOL_C, P_EOL_S: begin
          if (w_eol) begin
            w_p_nxt = P_IDLE;
            unique case (r_p)
              P_EOL_R: w_send_nxt  = 1'b1;
              P_EOL_C: w_clear_nxt = 1'b1;
              default: begin
                w_sel_nxt  = r_nib;
                w_selv_nxt = 1'b1;
              end
            endcase
          end else begin
            w_err_nxt = 1'b1;
            w_p_nxt   = P_DISCARD;
          end
        end
        P_DISCARD: begin
          if (w_eol)
            w_p_nxt = P_IDLE;
        end
        default: w_p_nxt = P_IDLE;
      endcase
    end
  end

  assign rx_data       = w_rx_data;
  assign rx_valid      = w_rx_valid;
  assign frame_err_cnt = w_ferr;
  assign send_req      = r_send;
  assign clear_req     = r_clear;
  assign sel           = r_sel;
  assign sel_valid     = r_selv;
  assign cmd_err       = r_err;

endmodule

// File: doc/debug_cmd_rx.md
Name: debug_cmd_rx

Overview:
UART command receiver for the debug console. It is the receive side of the 115200-baud link that the debug print path transmits on. It deserialises bytes from the host terminal and parses short ASCII line commands into one-cycle control pulses: report request, statistics clear, and channel select. These pulses drive the timing-debug reporting logic (send trigger, min/max reset, channel mux).

Parameters:
CLK_FREQ, 27000000, clock frequency in Hz
UART_FREQ, 115200, baud rate; BIT_DIV = CLK_FREQ/UART_FREQ rounded = 234, HALF_DIV = BIT_DIV/2 = 117

Ports:
clk_27m  input  1  system clock
reset_n  input  1  asynchronous active-low reset
uart_rx  input  1  serial line from host, idle high, asynchronous to clk_27m
rx_data  output 8  last received byte
rx_valid output 1  one-cycle pulse when rx_data is updated
send_req output 1  one-cycle pulse on a completed "R" command
clear_req output 1  one-cycle pulse on a completed "C" command
sel      output 8  channel select value set by the "Shh" command
sel_valid output 1  one-cycle pulse when sel is updated
cmd_err  output 1  one-cycle pulse on a malformed command
frame_err_cnt output 8  count of stop-bit errors, saturating at 255

Behaviour:
- Clock and reset: one clock, clk_27m. reset_n is asynchronous and active-low.
- Reset values: all outputs are 0. The uart_rx synchroniser flops reset to 1. Both FSMs reset to their idle state.
- Synchroniser: uart_rx passes through a 2-FF synchroniser before any use.
- RX FSM, RX_IDLE:
  - On synced line = 0, clear the bit counter and go to RX_START.
- RX FSM, RX_START:
  - Wait HALF_DIV cycles, then sample the line.
  - 0: go to RX_DATA.
  - 1: treat as a glitch and return to RX_IDLE with no output.
- RX FSM, RX_DATA:
  - Sample every BIT_DIV cycles, 8 bits, LSB first, into a shift register.
  - After bit 7, go to RX_STOP.
- RX FSM, RX_STOP:
  - Sample after BIT_DIV cycles.
  - 1: load rx_data and pulse rx_valid on the next cycle. Return to RX_IDLE.
  - 0: framing error. Drop the byte, increment frame_err_cnt (saturating at 255), go to RX_WAIT_HIGH.
- RX FSM, RX_WAIT_HIGH:
  - Stay until the line reads 1, then return to RX_IDLE. This prevents false starts during a break.
- RX latency: rx_valid rises at cycle HALF_DIV+9*BIT_DIV+1 = 2224 after the first synced low sample.
- Parser input: the parser consumes bytes only on rx_valid. EOL is 0x0A or 0x0D. Letters are case-insensitive ('R'/'r', 'C'/'c', 'S'/'s').
- Parser FSM, P_IDLE:
  - 'R' → P_EOL_R.
  - 'C' → P_EOL_C.
  - 'S' → P_HI.
  - EOL → stay in P_IDLE (empty line, no pulse).
  - Any other byte → pulse cmd_err, go to P_DISCARD.
- Parser FSM, P_HI and P_LO:
  - Accept hex digits 0-9, A-F, a-f into a nibble register (high nibble, then low).
  - A non-hex byte or EOL: pulse cmd_err and go to P_DISCARD. On EOL, return directly to P_IDLE instead.
- Parser FSM, P_EOL_R / P_EOL_C / P_EOL_S:
  - EOL: pulse send_req / clear_req / (load sel and pulse sel_valid), go to P_IDLE.
  - Any other byte: pulse cmd_err, go to P_DISCARD.
- Parser FSM, P_DISCARD:
  - Ignore bytes until EOL, then go to P_IDLE. No additional cmd_err pulses.
- Parser latency: a command pulse is asserted exactly one cycle after the rx_valid of its EOL byte.
- Pulse exclusivity: at most one of send_req/clear_req/sel_valid/cmd_err is high in any cycle.
- sel holds its value until the next valid "S" command. A malformed command never alters sel.
- Framing errors do not reset the parser; the dropped byte is simply absent from the stream.
- Reset mid-byte or mid-command: everything returns to the reset state immediately. The next complete frame is received normally.

Decomposition:
- Shared debug package holds:
  - BIT_DIV and HALF_DIV derivation
  - ASCII constants for 'R', 'C', 'S', LF, CR
  - RX and parser state encodings
- Natural sub-module: uart_rx_core, containing the synchroniser, RX FSM, rx_data/rx_valid and frame_err_cnt.
- debug_cmd_rx instantiates uart_rx_core and contains the parser FSM.

Test Plan:
1. Frame 0x55 with 234-cycle bits → rx_data=0x55, single rx_valid pulse 2224 cycles after the start edge, frame_err_cnt=0.
2. Bytes "R",0x0A → exactly one send_req pulse, one cycle after the second rx_valid. No other command pulses.
3. "S3A\r" → sel=0x3A and one sel_valid pulse. Then "S3G\n" → one cmd_err pulse and sel stays 0x3A.
4. Line held low for 10 bit times, then high → no rx_valid, frame_err_cnt=1. The following "c\n" → one clear_req pulse.
5. 50-cycle low glitch on an idle line → no rx_valid, frame_err_cnt unchanged. An immediately following "R\n" still works.
6. reset_n asserted during data bit 4 of a frame → all outputs 0 during reset. After release and line idle, frame 0xA5 → rx_data=0xA5.
